fc_ctrl: RTL and testbench

Sequencer for the fully-connected stage. It sits between `pool_fc_buffer` and the FC MAC array. On the buffer's start pulse it walks the 384-byte pooled feature map in 8-byte beats once per output neuron, and drives the matching weight-ROM address and the MAC clear/enable strobes. It then presents each finished neuron to the write-back stage through a valid/ready handshake.

---
 rtl/fc_pkg.sv | 40 ++++
 rtl/fc_ctrl_if.sv | 58 +++++
 rtl/fc_addr_gen.sv | 88 ++++++++
 rtl/fc_ctrl.sv | 205 ++++++++++++++++++++
 tb/tb_fc_ctrl.sv | 323 ++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/fc_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : fc_pkg
//  Description : Constants, state encoding and a width helper shared by the
//                fully-connected stage (fc_ctrl, pool_fc_buffer, FC MAC array).
//  Revision    : 1.0 - initial release
// ============================================================================
package fc_pkg;

    // Sequencer states. The encoding is explicit so that waveforms and any
    // downstream decoders see stable values.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_CLR   = 3'd1,
        ST_RUN   = 3'd2,
        ST_DRAIN = 3'd3,
        ST_OUT   = 3'd4,
        ST_DONE  = 3'd5
    } fc_state_t;

    localparam int unsigned FC_FM_BYTES = 384;
    localparam int unsigned FC_LANES    = 8;
    localparam int unsigned FC_N_OUT    = 10;
    localparam int unsigned FC_BEATS    = FC_FM_BYTES / FC_LANES;

    // Minimum weight-ROM address width able to reach every beat of every
    // neuron (addresses 0 .. n_out*beats-1).
    function automatic int unsigned fc_waddr_w(input int unsigned n_out,
                                               input int unsigned fm_bytes,
                                               input int unsigned lanes);
        int unsigned words;
        words = n_out * (fm_bytes / lanes);
        if (words <= 1) begin
            return 1;
        end
        return $clog2(words);
    endfunction

endpackage
`default_nettype wire

// File: rtl/fc_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module      : fc_ctrl_if
//  Description : Bus bundle between fc_ctrl and its neighbours.
//                i_fc_start     : start pulse from the pooled-feature buffer
//                o_fc_fm_addr   : buffer byte address (multiple of LANES)
//                o_fc_w_addr    : weight-ROM beat address
//                o_mac_clr/en/last : MAC array strobes
//                o_out_valid/o_out_idx/i_out_ready : write-back handshake
//                o_busy, o_fc_done : status
//                modport master : the sequencer side
//                modport slave  : the environment side
//  Revision    : 1.0 - initial release
// ============================================================================
interface fc_ctrl_if #(
    parameter int unsigned WADDR_W = 10
);
    logic               i_fc_start;
    logic [15:0]        o_fc_fm_addr;
    logic [WADDR_W-1:0] o_fc_w_addr;
    logic               o_mac_clr;
    logic               o_mac_en;
    logic               o_mac_last;
    logic               o_out_valid;
    logic [3:0]         o_out_idx;
    logic               i_out_ready;
    logic               o_busy;
    logic               o_fc_done;

    modport master (
        input  i_fc_start,
        input  i_out_ready,
        output o_fc_fm_addr,
        output o_fc_w_addr,
        output o_mac_clr,
        output o_mac_en,
        output o_mac_last,
        output o_out_valid,
        output o_out_idx,
        output o_busy,
        output o_fc_done
    );

    modport slave (
        output i_fc_start,
        output i_out_ready,
        input  o_fc_fm_addr,
        input  o_fc_w_addr,
        input  o_mac_clr,
        input  o_mac_en,
        input  o_mac_last,
        input  o_out_valid,
        input  o_out_idx,
        input  o_busy,
        input  o_fc_done
    );
endinterface
`default_nettype wire

// File: rtl/fc_addr_gen.sv
`default_nettype none
// ============================================================================
//  Module      : fc_addr_gen
//  Description : Beat and neuron counters for the FC sequencer plus the
//                feature-map and weight-ROM address computation.
//                Ports:
//                  clk, rst        : clock, synchronous active-high reset
//                  i_beat_clr      : restart the beat counter at 0
//                  i_beat_inc      : advance the beat counter
//                  i_neuron_clr    : restart the neuron counter at 0
//                  i_neuron_inc    : advance the neuron counter
//                  i_run           : addresses are driven only when high
//                  o_beat_last     : beat == BEATS-1
//                  o_neuron_last   : neuron == N_OUT-1
//                  o_neuron        : current neuron index
//                  o_fm_addr       : beat*LANES, zero outside RUN
//                  o_w_addr        : neuron*BEATS + beat, zero outside RUN
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_addr_gen
    import fc_pkg::*;
#(
    parameter int unsigned FM_BYTES = FC_FM_BYTES,
    parameter int unsigned LANES    = FC_LANES,
    parameter int unsigned N_OUT    = FC_N_OUT,
    parameter int unsigned WADDR_W  = 10
) (
    input  wire logic               clk,
    input  wire logic               rst,
    input  wire logic               i_beat_clr,
    input  wire logic               i_beat_inc,
    input  wire logic               i_neuron_clr,
    input  wire logic               i_neuron_inc,
    input  wire logic               i_run,
    output logic                    o_beat_last,
    output logic                    o_neuron_last,
    output logic [3:0]              o_neuron,
    output logic [15:0]             o_fm_addr,
    output logic [WADDR_W-1:0]      o_w_addr
);

    localparam int unsigned BEATS  = FM_BYTES / LANES;
    localparam int unsigned BEAT_W = (BEATS > 1) ? $clog2(BEATS) : 1;

    localparam logic [BEAT_W-1:0] c_beat_last   = BEAT_W'(BEATS - 1);
    localparam logic [3:0]        c_neuron_last = 4'(N_OUT - 1);

    logic [BEAT_W-1:0] r_beat;
    logic [3:0]        r_neuron;

    // Both counters park on their last value instead of wrapping; the FSM
    // always clears them before the next pass.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_beat   <= '0;
            r_neuron <= '0;
        end else begin
            if (i_beat_clr) begin
                r_beat <= '0;
            end else if (i_beat_inc && !o_beat_last) begin
                r_beat <= r_beat + 1'b1;
            end

            if (i_neuron_clr) begin
                r_neuron <= '0;
            end else if (i_neuron_inc && !o_neuron_last) begin
                r_neuron <= r_neuron + 1'b1;
            end
        end
    end

    assign o_beat_last   = (r_beat == c_beat_last);
    assign o_neuron_last = (r_neuron == c_neuron_last);
    assign o_neuron      = r_neuron;

    // Arithmetic is carried out directly at the output width; the legality
    // check in fc_ctrl guarantees neither result can wrap.
    logic [15:0]        w_fm_addr;
    logic [WADDR_W-1:0] w_w_addr;

    assign w_fm_addr = 16'(r_beat) * 16'(LANES);
    assign w_w_addr  = WADDR_W'(r_neuron) * WADDR_W'(BEATS) + WADDR_W'(r_beat);

    assign o_fm_addr = i_run ? w_fm_addr : '0;
    assign o_w_addr  = i_run ? w_w_addr  : '0;

endmodule
`default_nettype wire

// File: rtl/fc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : fc_ctrl
//  Description : Fully-connected stage sequencer. On i_fc_start it walks the
//                pooled feature map once per output neuron, drives the
//                weight-ROM address and MAC strobes, and hands each finished
//                neuron to write-back over a valid/ready handshake.
//                Ports:
//                  clk, rst : clock, synchronous active-high reset
//                  bus      : fc_ctrl_if.master (start, addresses, MAC
//                             strobes, output handshake, status)
//                  o_perf_cycles, o_perf_stall : optional performance
//                             counters, present only with FC_CTRL_PERF_EN
//                Build option: define FC_CTRL_PERF_EN to add the counters.
//  Revision    : 1.0 - initial release
// ============================================================================
module fc_ctrl
    import fc_pkg::*;
#(
    parameter int unsigned FM_BYTES = FC_FM_BYTES,
    parameter int unsigned LANES    = FC_LANES,
    parameter int unsigned N_OUT    = FC_N_OUT,
    parameter int unsigned WADDR_W  = 10
) (
    input  wire logic   clk,
    input  wire logic   rst,
`ifdef FC_CTRL_PERF_EN
    output logic [31:0] o_perf_cycles,
    output logic [31:0] o_perf_stall,
`endif
    fc_ctrl_if.master   bus
);

    // ------------------------------------------------------------------
    // Elaboration-time parameter legality
    // ------------------------------------------------------------------
    generate
        if (LANES == 0 || FM_BYTES < LANES || (FM_BYTES % LANES) != 0 ||
            FM_BYTES > 65536 || N_OUT == 0 || N_OUT > 16 || WADDR_W > 32 ||
            WADDR_W < fc_waddr_w(N_OUT, FM_BYTES, LANES)) begin : g_param_check
            $error("fc_ctrl: illegal FM_BYTES/LANES/N_OUT/WADDR_W combination");
        end
    endgenerate

    // ------------------------------------------------------------------
    // State and handshake decode
    // ------------------------------------------------------------------
    fc_state_t  r_state;
    fc_state_t  w_state_next;

    logic       w_in_run;
    logic       w_in_clr;
    logic       w_start_taken;
    logic       w_accept;
    logic       w_beat_last;
    logic       w_neuron_last;
    logic [3:0] w_neuron;

    assign w_in_run      = (r_state == ST_RUN);
    assign w_in_clr      = (r_state == ST_CLR);
    assign w_start_taken = (r_state == ST_IDLE) && bus.i_fc_start;
    assign w_accept      = (r_state == ST_OUT) && bus.i_out_ready;

    // ------------------------------------------------------------------
    // Counters and address generation
    // ------------------------------------------------------------------
    fc_addr_gen #(
        .FM_BYTES (FM_BYTES),
        .LANES    (LANES),
        .N_OUT    (N_OUT),
        .WADDR_W  (WADDR_W)
    ) u_addr_gen (
        .clk           (clk),
        .rst           (rst),
        .i_beat_clr    (w_in_clr),
        .i_beat_inc    (w_in_run),
        .i_neuron_clr  (w_start_taken),
        .i_neuron_inc  (w_accept),
        .i_run         (w_in_run),
        .o_beat_last   (w_beat_last),
        .o_neuron_last (w_neuron_last),
        .o_neuron      (w_neuron),
        .o_fm_addr     (bus.o_fc_fm_addr),
        .o_w_addr      (bus.o_fc_w_addr)
    );

    // ------------------------------------------------------------------
    // FSM
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    logic w_mac_clr;
    logic w_out_valid;
    logic w_busy;
    logic w_done;

    always_comb begin
        w_state_next = r_state;
        w_mac_clr    = 1'b0;
        w_out_valid  = 1'b0;
        w_busy       = 1'b1;
        w_done       = 1'b0;
        case (r_state)
            ST_IDLE: begin
                w_busy = 1'b0;
                if (bus.i_fc_start) begin
                    w_state_next = ST_CLR;
                end
            end
            ST_CLR: begin
                w_mac_clr    = 1'b1;
                w_state_next = ST_RUN;
            end
            ST_RUN: begin
                if (w_beat_last) begin
                    w_state_next = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                // Cycle in which the delayed enable of the final beat lands.
                w_state_next = ST_OUT;
            end
            ST_OUT: begin
                w_out_valid = 1'b1;
                if (bus.i_out_ready) begin
                    w_state_next = w_neuron_last ? ST_DONE : ST_CLR;
                end
            end
            ST_DONE: begin
                // Start is not looked at here, so a pulse on the DONE->IDLE
                // edge is dropped.
                w_done       = 1'b1;
                w_state_next = ST_IDLE;
            end
            default: begin
                w_busy       = 1'b0;
                w_state_next = ST_IDLE;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Enable pipeline: the buffer registers its read address, so data for
    // a RUN beat arrives one cycle later. The MAC strobes are delayed to
    // line up with it.
    // ------------------------------------------------------------------
    logic r_mac_en;
    logic r_mac_last;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_mac_en   <= 1'b0;
            r_mac_last <= 1'b0;
        end else begin
            r_mac_en   <= w_in_run;
            r_mac_last <= w_in_run && w_beat_last;
        end
    end

    assign bus.o_mac_clr   = w_mac_clr;
    assign bus.o_mac_en    = r_mac_en;
    assign bus.o_mac_last  = r_mac_last;
    assign bus.o_out_valid = w_out_valid;
    assign bus.o_out_idx   = w_out_valid ? w_neuron : 4'd0;
    assign bus.o_busy      = w_busy;
    assign bus.o_fc_done   = w_done;

`ifdef FC_CTRL_PERF_EN
    // ------------------------------------------------------------------
    // Performance counters. The DONE cycle is the reporting cycle: the
    // figures visible alongside o_fc_done are final and held until the
    // next accepted start.
    // ------------------------------------------------------------------
    logic [31:0] r_perf_cycles;
    logic [31:0] r_perf_stall;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else if (w_start_taken) begin
            r_perf_cycles <= '0;
            r_perf_stall  <= '0;
        end else begin
            if (r_state != ST_IDLE && r_state != ST_DONE && r_perf_cycles != '1) begin
                r_perf_cycles <= r_perf_cycles + 32'd1;
            end
            if (r_state == ST_OUT && !bus.i_out_ready && r_perf_stall != '1) begin
                r_perf_stall <= r_perf_stall + 32'd1;
            end
        end
    end

    assign o_perf_cycles = r_perf_cycles;
    assign o_perf_stall  = r_perf_stall;
`endif

endmodule
`default_nettype wire

// File: tb/tb_fc_ctrl.sv
`default_nettype none
// ============================================================================
//  Module      : tb_fc_ctrl
//  Description : Directed self-checking bench for fc_ctrl (default params).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_fc_ctrl;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_err;

    fc_ctrl_if #(.WADDR_W(10)) bus ();

`ifdef FC_CTRL_PERF_EN
    logic [31:0] perf_cycles;
    logic [31:0] perf_stall;
`endif

    fc_ctrl #(
        .FM_BYTES (384),
        .LANES    (8),
        .N_OUT    (10),
        .WADDR_W  (10)
    ) dut (
        .clk           (clk),
        .rst           (rst),
`ifdef FC_CTRL_PERF_EN
        .o_perf_cycles (perf_cycles),
        .o_perf_stall  (perf_stall),
`endif
        .bus           (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // {fm_addr, w_addr, clr, en, last, valid, idx, busy, done}
    function automatic logic [35:0] snap();
        return {bus.o_fc_fm_addr, bus.o_fc_w_addr, bus.o_mac_clr, bus.o_mac_en,
                bus.o_mac_last, bus.o_out_valid, bus.o_out_idx, bus.o_busy,
                bus.o_fc_done};
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench observing cycle 1 (the cycle after the start edge).
    task automatic do_start();
        bus.i_fc_start = 1'b1;
        step();
        bus.i_fc_start = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) step();
        n_cmp++;
        if (snap() !== 36'h0) begin
            n_err++;
            $display("FAIL reset_outputs: got %h expected %h", snap(), 36'h0);
        end
        rst = 1'b0;
        repeat (2) step();
        n_cmp++;
        if (snap() !== 36'h0) begin
            n_err++;
            $display("FAIL idle_outputs: got %h expected %h", snap(), 36'h0);
        end
    endtask

    // Full pass with ready high; every cycle compared against a phase model:
    // each neuron is 51 cycles (CLR, 48 RUN, DRAIN, OUT), then DONE.
    task automatic test_single_run();
        int n, p, done_cyc, en_n0, en_total, last_total;
        logic [35:0] exp_v;
        logic [15:0] e_fm;
        logic [9:0]  e_w;
        logic e_clr, e_en, e_last, e_valid, e_busy, e_done;
        logic [3:0]  e_idx;
        done_cyc = 0; en_n0 = 0; en_total = 0; last_total = 0;
        bus.i_out_ready = 1'b1;
        do_start();
        for (int cyc = 1; cyc <= 520; cyc++) begin
            e_fm = '0; e_w = '0; e_clr = 0; e_en = 0; e_last = 0;
            e_valid = 0; e_idx = '0; e_busy = 0; e_done = 0;
            if (cyc <= 510) begin
                n = (cyc - 1) / 51;
                p = (cyc - 1) % 51;
                e_busy = 1'b1;
                if (p == 0) e_clr = 1'b1;
                if (p >= 1 && p <= 48) begin
                    e_fm = 16'((p - 1) * 8);
                    e_w  = 10'(n * 48 + p - 1);
                end
                if (p >= 2 && p <= 49) e_en = 1'b1;
                if (p == 49) e_last = 1'b1;
                if (p == 50) begin
                    e_valid = 1'b1;
                    e_idx   = 4'(n);
                end
            end else if (cyc == 511) begin
                e_busy = 1'b1;
                e_done = 1'b1;
            end
            exp_v = {e_fm, e_w, e_clr, e_en, e_last, e_valid, e_idx, e_busy, e_done};
            n_cmp++;
            if (snap() !== exp_v) begin
                n_err++;
                $display("FAIL run_cycle_%0d: got %h expected %h", cyc, snap(), exp_v);
            end
            if (bus.o_mac_en === 1'b1) begin
                en_total++;
                if (cyc <= 51) en_n0++;
            end
            if (bus.o_mac_last === 1'b1) last_total++;
            if (bus.o_fc_done === 1'b1 && done_cyc == 0) done_cyc = cyc;
            step();
        end
        n_cmp++;
        if (done_cyc !== 511) begin
            n_err++;
            $display("FAIL done_latency: got %0d expected %0d", done_cyc, 511);
        end
        n_cmp++;
        if (en_n0 !== 48) begin
            n_err++;
            $display("FAIL en_pulses_n0: got %0d expected %0d", en_n0, 48);
        end
        n_cmp++;
        if (en_total !== 480 || last_total !== 10) begin
            n_err++;
            $display("FAIL en_last_totals: got %0d/%0d expected 480/10", en_total, last_total);
        end
    endtask

    task automatic test_backpressure();
        int stall_left, done_cyc, done_cnt, stall_start;
        logic prev_stalled, prev_accept3;
        stall_left = 5; done_cyc = 0; done_cnt = 0; stall_start = 0;
        prev_stalled = 1'b0; prev_accept3 = 1'b0;
        do_start();
        for (int cyc = 1; cyc <= 530; cyc++) begin
            if (prev_stalled) begin
                n_cmp++;
                if (bus.o_out_valid !== 1'b1 || bus.o_out_idx !== 4'd3 || bus.o_mac_clr !== 1'b0) begin
                    n_err++;
                    $display("FAIL stall_hold_cycle_%0d: got valid=%b idx=%0d clr=%b expected valid=1 idx=3 clr=0",
                             cyc, bus.o_out_valid, bus.o_out_idx, bus.o_mac_clr);
                end
            end
            if (prev_accept3) begin
                n_cmp++;
                if (bus.o_mac_clr !== 1'b1 || bus.o_out_valid !== 1'b0) begin
                    n_err++;
                    $display("FAIL after_accept3: got clr=%b valid=%b expected clr=1 valid=0",
                             bus.o_mac_clr, bus.o_out_valid);
                end
            end
            prev_accept3 = 1'b0;
            if (bus.o_fc_done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
`ifdef FC_CTRL_PERF_EN
                n_cmp++;
                if (perf_cycles !== 32'd515 || perf_stall !== 32'd5) begin
                    n_err++;
                    $display("FAIL perf_counters: got %0d/%0d expected 515/5", perf_cycles, perf_stall);
                end
`endif
            end
            if (bus.o_out_valid === 1'b1 && bus.o_out_idx === 4'd3 && stall_left > 0) begin
                if (stall_left == 5) stall_start = cyc;
                bus.i_out_ready = 1'b0;
                stall_left--;
                prev_stalled = 1'b1;
            end else begin
                if (bus.o_out_valid === 1'b1 && bus.o_out_idx === 4'd3) prev_accept3 = 1'b1;
                bus.i_out_ready = 1'b1;
                prev_stalled = 1'b0;
            end
            step();
        end
        bus.i_out_ready = 1'b1;
        n_cmp++;
        if (stall_start !== 204) begin
            n_err++;
            $display("FAIL n3_out_cycle: got %0d expected %0d", stall_start, 204);
        end
        n_cmp++;
        if (done_cyc !== 516 || done_cnt !== 1) begin
            n_err++;
            $display("FAIL bp_done: got cycle %0d count %0d expected cycle 516 count 1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_extra_start();
        int done_cyc, done_cnt;
        done_cyc = 0; done_cnt = 0;
        bus.i_out_ready = 1'b1;
        do_start();
        for (int cyc = 1; cyc <= 560; cyc++) begin
            if (bus.o_fc_done === 1'b1) begin
                done_cnt++;
                if (done_cyc == 0) done_cyc = cyc;
            end
            if (cyc == 11) begin
                n_cmp++;
                if (bus.o_fc_fm_addr !== 16'd72) begin
                    n_err++;
                    $display("FAIL xstart_fm_addr: got %0d expected %0d", bus.o_fc_fm_addr, 72);
                end
            end
            if (cyc == 54) begin
                n_cmp++;
                if (bus.o_fc_w_addr !== 10'd49) begin
                    n_err++;
                    $display("FAIL xstart_w_addr: got %0d expected %0d", bus.o_fc_w_addr, 49);
                end
            end
            if (cyc == 512 || cyc == 540) begin
                n_cmp++;
                if (bus.o_busy !== 1'b0) begin
                    n_err++;
                    $display("FAIL xstart_idle_cycle_%0d: got busy=%b expected 0", cyc, bus.o_busy);
                end
            end
            bus.i_fc_start = (cyc == 10 || cyc == 51 || cyc == 511) ? 1'b1 : 1'b0;
            step();
        end
        bus.i_fc_start = 1'b0;
        n_cmp++;
        if (done_cyc !== 511 || done_cnt !== 1) begin
            n_err++;
            $display("FAIL xstart_done: got cycle %0d count %0d expected cycle 511 count 1", done_cyc, done_cnt);
        end
    endtask

    task automatic test_mid_reset();
        int done_cnt, busy_cnt, done_cyc;
        done_cnt = 0; busy_cnt = 0; done_cyc = 0;
        bus.i_out_ready = 1'b1;
        do_start();
        for (int c = 1; c < 317; c++) step();
        n_cmp++;
        if (bus.o_fc_w_addr !== 10'd297 || bus.o_fc_fm_addr !== 16'd72) begin
            n_err++;
            $display("FAIL n6_run_addr: got w=%0d fm=%0d expected w=297 fm=72", bus.o_fc_w_addr, bus.o_fc_fm_addr);
        end
        rst = 1'b1;
        step();
        n_cmp++;
        if (snap() !== 36'h0) begin
            n_err++;
            $display("FAIL midreset_outputs: got %h expected %h", snap(), 36'h0);
        end
        rst = 1'b0;
        for (int c = 0; c < 300; c++) begin
            if (bus.o_fc_done === 1'b1) done_cnt++;
            if (bus.o_busy === 1'b1) busy_cnt++;
            step();
        end
        n_cmp++;
        if (done_cnt !== 0 || busy_cnt !== 0) begin
            n_err++;
            $display("FAIL midreset_quiet: got done=%0d busy=%0d expected 0/0", done_cnt, busy_cnt);
        end
        do_start();
        n_cmp++;
        if (bus.o_mac_clr !== 1'b1) begin
            n_err++;
            $display("FAIL restart_clr: got %b expected 1", bus.o_mac_clr);
        end
        step();
        n_cmp++;
        if (bus.o_fc_fm_addr !== 16'd0 || bus.o_fc_w_addr !== 10'd0 || bus.o_busy !== 1'b1) begin
            n_err++;
            $display("FAIL restart_beat0: got fm=%0d w=%0d busy=%b expected 0/0/1",
                     bus.o_fc_fm_addr, bus.o_fc_w_addr, bus.o_busy);
        end
        step();
        n_cmp++;
        if (bus.o_fc_fm_addr !== 16'd8 || bus.o_fc_w_addr !== 10'd1) begin
            n_err++;
            $display("FAIL restart_beat1: got fm=%0d w=%0d expected 8/1", bus.o_fc_fm_addr, bus.o_fc_w_addr);
        end
        for (int cyc = 3; cyc <= 520; cyc++) begin
            if (bus.o_fc_done === 1'b1 && done_cyc == 0) done_cyc = cyc;
            step();
        end
        n_cmp++;
        if (done_cyc !== 511) begin
            n_err++;
            $display("FAIL restart_done: got %0d expected %0d", done_cyc, 511);
        end
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        rst = 1'b1;
        bus.i_fc_start  = 1'b0;
        bus.i_out_ready = 1'b1;
        test_reset();
        test_single_run();
        test_backpressure();
        test_extra_start();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
